// File: rtl/vram_pkg.sv
// Shared VRAM geometry, pixel and blitter command types.
// Used by the transformer, vram and vram_blitter blocks.
package vram_pkg;

   localparam int IMG_W  = 160;
   localparam int IMG_H  = 120;
   localparam int ADDR_W = 15;
   localparam int DATA_W = 13;

   typedef logic [DATA_W-1:0] pixel_t;

   typedef struct packed {
      logic signed [11:0] x;
      logic signed [11:0] y;
      logic [8:0]         w;
      logic [7:0]         h;
   } blit_cmd_t;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      DONE
   } blit_state_e;

   // Row-major VRAM address; only meaningful for in-bounds pixels.
   function automatic logic [ADDR_W-1:0] pix_addr(
      input logic [12:0] px,
      input logic [12:0] py
   );
      return ADDR_W'(py) * ADDR_W'(IMG_W) + ADDR_W'(px);
   endfunction

endpackage

// File: rtl/blit_addr_gen.sv
// Column/row walker for a blit rectangle: clip test and VRAM address
// of the current pixel, plus the last-pixel flag.
module blit_addr_gen
   import vram_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              adv,
   input  blit_cmd_t         cmd,
   output logic              in_bounds,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);

   logic [8:0]  col;
   logic [7:0]  row;
   logic [12:0] px;
   logic [12:0] py;
   logic        col_end;
   logic        row_end;

   // 13-bit two's complement sums; operand ranges cannot overflow.
   assign px = {cmd.x[11], cmd.x} + {4'b0, col};
   assign py = {cmd.y[11], cmd.y} + {5'b0, row};

   assign col_end = (col == cmd.w - 9'd1);
   assign row_end = (row == cmd.h - 8'd1);
   assign last    = col_end && row_end;

   assign in_bounds = !px[12] && (px < 13'(IMG_W))
                   && !py[12] && (py < 13'(IMG_H));

   assign addr = pix_addr(px, py);

   // Raster walk: step column per accepted pixel, wrap into next row.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         col <= '0;
         row <= '0;
      end else if (adv) begin
         if (col_end) begin
            col <= '0;
            row <= row + 8'd1;
         end else begin
            col <= col + 9'd1;
         end
      end
   end

endmodule

// File: rtl/vram_blitter.sv
// Rectangle blitter into the VRAM write port, clipped per pixel.
// Option: BLIT_TRANSPARENT_SKIP_EN skips in-bounds pixels with alpha clear.
module vram_blitter
   import vram_pkg::*;
#(
   parameter int VBLANK_ONLY = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               vblank,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic signed [11:0] cmd_x,
   input  logic signed [11:0] cmd_y,
   input  logic [8:0]         cmd_w,
   input  logic [7:0]         cmd_h,
   input  logic               s_valid,
   output logic               s_ready,
   input  pixel_t             s_data,
   output logic               we,
   output logic [ADDR_W-1:0]  waddr,
   output pixel_t             wdata,
   output logic               busy,
   output logic               done
);

   blit_state_e       state;
   blit_cmd_t         cmd_q;
   logic              hs;
   logic              clr;
   logic              in_bounds;
   logic              last;
   logic              wr_ok;
   logic [ADDR_W-1:0] addr;

   assign s_ready = (state == WRITE)
                 && ((VBLANK_ONLY != 0) ? vblank : 1'b1);
   assign hs  = s_valid && s_ready;
   assign clr = (state == IDLE) && cmd_valid;

`ifdef BLIT_TRANSPARENT_SKIP_EN
   assign wr_ok = in_bounds && s_data[0];
`else
   assign wr_ok = in_bounds;
`endif

   blit_addr_gen u_addr (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .adv       (hs),
      .cmd       (cmd_q),
      .in_bounds (in_bounds),
      .addr      (addr),
      .last      (last)
   );

   // Command FSM with registered handshake, status and write-port outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cmd_q     <= '0;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         we        <= 1'b0;
         waddr     <= '0;
         wdata     <= '0;
      end else begin
         we <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  cmd_q     <= '{x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h};
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  if (cmd_w == 9'd0 || cmd_h == 8'd0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= WRITE;
                  end
               end
            end
            WRITE: begin
               if (hs) begin
                  if (wr_ok) begin
                     we    <= 1'b1;
                     waddr <= addr;
                     wdata <= s_data;
                  end
                  if (last) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            DONE: begin
               state     <= IDLE;
               done      <= 1'b0;
               busy      <= 1'b0;
               cmd_ready <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               done      <= 1'b0;
               busy      <= 1'b0;
               cmd_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vram_blitter.sv
// Scoreboard bench for vram_blitter: a rectangle/clip model
// predicts writes and done pulses, a monitor checks the port.
module tb_vram_blitter;
   import vram_pkg::*;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               vblank = 1'b1;
   logic               cmd_valid = 1'b0;
   logic               cmd_ready;
   logic signed [11:0] cmd_x = '0;
   logic signed [11:0] cmd_y = '0;
   logic [8:0]         cmd_w = '0;
   logic [7:0]         cmd_h = '0;
   logic               s_valid = 1'b0;
   logic               s_ready;
   pixel_t             s_data = '0;
   logic               we;
   logic [ADDR_W-1:0]  waddr;
   pixel_t             wdata;
   logic               busy;
   logic               done;

   typedef struct {
      int addr;
      int data;
   } wr_t;

   wr_t    exp_q[$];
   bit     done_q[$];
   wr_t    mon_e;
   int     errors = 0;
   int     checks = 0;
   int     hs_count = 0;
   bit     mon_en = 1'b0;
   bit     rnd_vb = 1'b0;
   pixel_t d[$];

   vram_blitter #(.VBLANK_ONLY(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .vblank    (vblank),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_x     (cmd_x),
      .cmd_y     (cmd_y),
      .cmd_w     (cmd_w),
      .cmd_h     (cmd_h),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Monitor: every write and done pulse is matched against the model.
   always @(negedge clk) begin
      if (mon_en) begin
         if (s_valid && s_ready) hs_count++;
         if (we) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got addr %0d expected none",
                        waddr);
            end else begin
               mon_e = exp_q.pop_front();
               chk("waddr", int'(waddr), mon_e.addr);
               chk("wdata", int'(wdata), mon_e.data);
            end
         end
         if (done) begin
            if (done_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done=1 expected 0");
            end else begin
               chk("we_with_done", int'(we), int'(done_q.pop_front()));
            end
         end
      end
   end

   // Reference: walk the rectangle in raster order and clip each pixel.
   task automatic model(input int x, input int y, input int w,
                        input int h, input int n, input bit want_done);
      bit wr;
      int px;
      int py;
      for (int k = 0; k < n; k++) begin
         px = x + (k % w);
         py = y + (k / w);
         wr = (px >= 0) && (px < IMG_W) && (py >= 0) && (py < IMG_H);
`ifdef BLIT_TRANSPARENT_SKIP_EN
         wr = wr && d[k][0];
`endif
         if (wr) exp_q.push_back('{addr: py * IMG_W + px, data: int'(d[k])});
         if (want_done && k == w * h - 1) done_q.push_back(wr);
      end
      if (want_done && w * h == 0) done_q.push_back(1'b0);
   endtask

   task automatic gen_data(input int n);
      d = {};
      for (int k = 0; k < n; k++) d.push_back(pixel_t'($urandom));
   endtask

   task automatic issue(input int x, input int y, input int w, input int h);
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            cmd_x = 12'(x);
            cmd_y = 12'(y);
            cmd_w = 9'(w);
            cmd_h = 8'(h);
            cmd_valid = 1'b1;
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            return;
         end
      end
      checks++;
      errors++;
      $display("FAIL cmd_timeout: got cmd_ready=0 expected 1");
   endtask

   task automatic send_px(input pixel_t pd);
      s_valid = 1'b1;
      s_data  = pd;
      for (int i = 0; i < 1000; i++) begin
         if (rnd_vb) vblank = ($urandom_range(9) < 6);
         @(negedge clk);
         if (s_ready) begin
            @(posedge clk);
            #1;
            s_valid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      s_valid = 1'b0;
      checks++;
      errors++;
      $display("FAIL px_timeout: got s_ready=0 expected 1");
   endtask

   task automatic run_cmd(input int x, input int y, input int w, input int h);
      gen_data(w * h);
      model(x, y, w, h, w * h, 1'b1);
      issue(x, y, w, h);
      for (int k = 0; k < w * h; k++) send_px(d[k]);
   endtask

   task automatic drain();
      repeat (3) @(negedge clk);
      chk("exp_q_empty", exp_q.size(), 0);
      chk("done_q_empty", done_q.size(), 0);
   endtask

   initial begin
      int hs0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_cmd_ready", int'(cmd_ready), 1);
      chk("rst_s_ready", int'(s_ready), 0);
      chk("rst_we", int'(we), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_waddr", int'(waddr), 0);
      chk("rst_wdata", int'(wdata), 0);
      mon_en = 1'b1;

      run_cmd(10, 20, 4, 2);
      drain();
      run_cmd(-2, 0, 4, 1);
      drain();
      run_cmd(158, 119, 4, 2);
      drain();

      // vblank gap after 3 pixels, plus a command offered while busy
      gen_data(8);
      model(50, 50, 4, 2, 8, 1'b1);
      issue(50, 50, 4, 2);
      for (int k = 0; k < 3; k++) send_px(d[k]);
      vblank  = 1'b0;
      s_valid = 1'b1;
      s_data  = d[3];
      cmd_x = 12'sd0;
      cmd_y = 12'sd0;
      cmd_w = 9'd1;
      cmd_h = 8'd1;
      cmd_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         chk("gap_s_ready", int'(s_ready), 0);
         if (i > 0) chk("gap_we", int'(we), 0);
         if (i < 4) chk("busy_cmd_ready", int'(cmd_ready), 0);
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      vblank = 1'b1;
      for (int k = 3; k < 8; k++) send_px(d[k]);
      drain();

      // zero-width command
      hs0 = hs_count;
      s_valid = 1'b1;
      d = {};
      model(5, 5, 0, 3, 0, 1'b1);
      issue(5, 5, 0, 3);
      @(negedge clk);
      chk("w0_busy", int'(busy), 1);
      chk("w0_done", int'(done), 1);
      chk("w0_cmd_ready", int'(cmd_ready), 0);
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("w0_busy_after", int'(busy), 0);
      chk("w0_cmd_ready_after", int'(cmd_ready), 1);
      s_valid = 1'b0;
      chk("w0_handshakes", hs_count - hs0, 0);
      drain();

      // reset mid-rectangle after 3 pixels
      gen_data(8);
      model(20, 30, 4, 2, 3, 1'b0);
      issue(20, 30, 4, 2);
      for (int k = 0; k < 3; k++) send_px(d[k]);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_we", int'(we), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_cmd_ready", int'(cmd_ready), 1);
      chk("abort_done", int'(done), 0);
      repeat (3) begin
         @(negedge clk);
         chk("abort_no_done", int'(done), 0);
      end
      drain();

      // randomized rectangles with vblank toggling
      rnd_vb = 1'b1;
      for (int t = 0; t < 25; t++) begin
         run_cmd(int'($urandom_range(177)) - 12,
                 int'($urandom_range(130)) - 6,
                 int'($urandom_range(10)),
                 int'($urandom_range(4)));
      end
      rnd_vb = 1'b0;
      vblank = 1'b1;
      repeat (5) @(negedge clk);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
